// File: rtl/lsu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_mem_arbiter
//   Round-robin arbiter that funnels NUM_LSUS load/store units onto a single
//   data-memory port. Only one memory transaction is in flight at a time.
//   The flow is IDLE -> MEM_READ/MEM_WRITE -> RELEASE -> IDLE.
//
// Parameters
//   NUM_LSUS        number of requester channels (2..16)
//   ADDR_BITS       memory address width
//   DATA_BITS       memory data width
//   TIMEOUT_CYCLES  watchdog limit (only used with LSU_ARB_TIMEOUT_EN)
//
// Ports
//   clk, reset                         clock, async active-low reset
//   lsu_read_valid/_address            per-LSU load request (slice i = LSU i)
//   lsu_read_ready/_data               per-LSU load completion + returned data
//   lsu_write_valid/_address/_data     per-LSU store request
//   lsu_write_ready                    per-LSU store completion
//   mem_read_valid/_address            load request to memory
//   mem_read_ready/_data               load response from memory
//   mem_write_valid/_address/_data     store request to memory
//   mem_write_ready                    store acknowledge
//   busy                               high whenever not IDLE
//   grant_id                           current / last granted LSU
//   timeout_error                      sticky watchdog flag
//
// Build option
//   LSU_ARB_TIMEOUT_EN  when defined, a watchdog completes a stalled memory
//                       transaction after TIMEOUT_CYCLES cycles (read data 0)
//                       and sets timeout_error; otherwise MEM_* waits forever.
// ---------------------------------------------------------------------------
module lsu_mem_arbiter #(
  parameter int unsigned NUM_LSUS       = 4,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LSUS-1:0]             lsu_read_valid,
  input  logic [NUM_LSUS*ADDR_BITS-1:0]   lsu_read_address,
  output logic [NUM_LSUS-1:0]             lsu_read_ready,
  output logic [NUM_LSUS*DATA_BITS-1:0]   lsu_read_data,
  input  logic [NUM_LSUS-1:0]             lsu_write_valid,
  input  logic [NUM_LSUS*ADDR_BITS-1:0]   lsu_write_address,
  input  logic [NUM_LSUS*DATA_BITS-1:0]   lsu_write_data,
  output logic [NUM_LSUS-1:0]             lsu_write_ready,
  output logic                            mem_read_valid,
  output logic [ADDR_BITS-1:0]            mem_read_address,
  input  logic                            mem_read_ready,
  input  logic [DATA_BITS-1:0]            mem_read_data,
  output logic                            mem_write_valid,
  output logic [ADDR_BITS-1:0]            mem_write_address,
  output logic [DATA_BITS-1:0]            mem_write_data,
  input  logic                            mem_write_ready,
  output logic                            busy,
  output logic [$clog2(NUM_LSUS)-1:0]     grant_id,
  output logic                            timeout_error
);

  localparam int unsigned IDW   = $clog2(NUM_LSUS);
  localparam logic [IDW:0] N_EXT = (IDW+1)'(NUM_LSUS);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_LSUS - 1);

  if (NUM_LSUS < 2 || NUM_LSUS > 16) begin : g_bad_num_lsus
    $error("lsu_mem_arbiter: NUM_LSUS must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_mem_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    MEM_WRITE,
    RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic                   mrv_q, mrv_d;
  logic                   mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]   mra_q, mra_d;
  logic [ADDR_BITS-1:0]   mwa_q, mwa_d;
  logic [DATA_BITS-1:0]   mwd_q, mwd_d;
  logic [NUM_LSUS-1:0]    rrdy_q, rrdy_d;
  logic [NUM_LSUS-1:0]    wrdy_q, wrdy_d;
  logic [DATA_BITS-1:0]   rdata_q [NUM_LSUS];
  logic [DATA_BITS-1:0]   rdata_d [NUM_LSUS];

`ifdef LSU_ARB_TIMEOUT_EN
  localparam int unsigned  CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Per-channel views of the flattened request buses
  logic [ADDR_BITS-1:0] rd_addr_a [NUM_LSUS];
  logic [ADDR_BITS-1:0] wr_addr_a [NUM_LSUS];
  logic [DATA_BITS-1:0] wr_data_a [NUM_LSUS];

  for (genvar i = 0; i < NUM_LSUS; i++) begin : g_chan
    assign rd_addr_a[i] = lsu_read_address[i*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_a[i] = lsu_write_address[i*ADDR_BITS +: ADDR_BITS];
    assign wr_data_a[i] = lsu_write_data[i*DATA_BITS +: DATA_BITS];
    assign lsu_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
  end

  // Round-robin scan: first requester at or after rr_ptr, wrapping modulo
  // NUM_LSUS (which need not be a power of two).
  logic           req_found;
  logic [IDW-1:0] req_idx;

  always_comb begin
    logic [IDW:0] cand;
    cand      = '0;
    req_found = 1'b0;
    req_idx   = '0;
    for (int unsigned k = 0; k < NUM_LSUS; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!req_found && (lsu_read_valid[cand[IDW-1:0]] || lsu_write_valid[cand[IDW-1:0]])) begin
        req_found = 1'b1;
        req_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    mrv_d    = mrv_q;
    mwv_d    = mwv_q;
    mra_d    = mra_q;
    mwa_d    = mwa_q;
    mwd_d    = mwd_q;
    rrdy_d   = rrdy_q;
    wrdy_d   = wrdy_q;
    rdata_d  = rdata_q;
`ifdef LSU_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d = req_idx;
`ifdef LSU_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          // Read wins when both requests are up on the granted channel
          if (lsu_read_valid[req_idx]) begin
            mrv_d   = 1'b1;
            mra_d   = rd_addr_a[req_idx];
            state_d = MEM_READ;
          end else begin
            mwv_d   = 1'b1;
            mwa_d   = wr_addr_a[req_idx];
            mwd_d   = wr_data_a[req_idx];
            state_d = MEM_WRITE;
          end
        end
      end

      MEM_READ: begin
        if (mem_read_ready) begin
          rdata_d[grant_q] = mem_read_data;
          mrv_d            = 1'b0;
          rrdy_d[grant_q]  = 1'b1;
          state_d          = RELEASE;
        end
`ifdef LSU_ARB_TIMEOUT_EN
        else if (cnt_q == T_LAST) begin
          rdata_d[grant_q] = '0;
          mrv_d            = 1'b0;
          rrdy_d[grant_q]  = 1'b1;
          timeout_d        = 1'b1;
          state_d          = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      MEM_WRITE: begin
        if (mem_write_ready) begin
          mwv_d           = 1'b0;
          wrdy_d[grant_q] = 1'b1;
          state_d         = RELEASE;
        end
`ifdef LSU_ARB_TIMEOUT_EN
        else if (cnt_q == T_LAST) begin
          mwv_d           = 1'b0;
          wrdy_d[grant_q] = 1'b1;
          timeout_d       = 1'b1;
          state_d         = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      RELEASE: begin
        // Hold ready until the granted LSU withdraws the request it was served
        if ((rrdy_q[grant_q] && !lsu_read_valid[grant_q]) ||
            (wrdy_q[grant_q] && !lsu_write_valid[grant_q])) begin
          rrdy_d[grant_q] = 1'b0;
          wrdy_d[grant_q] = 1'b0;
          rr_ptr_d        = (grant_q == LAST_IDX) ? '0 : grant_q + IDW'(1);
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      mrv_q    <= 1'b0;
      mwv_q    <= 1'b0;
      mra_q    <= '0;
      mwa_q    <= '0;
      mwd_q    <= '0;
      rrdy_q   <= '0;
      wrdy_q   <= '0;
      rdata_q  <= '{default: '0};
`ifdef LSU_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      mrv_q    <= mrv_d;
      mwv_q    <= mwv_d;
      mra_q    <= mra_d;
      mwa_q    <= mwa_d;
      mwd_q    <= mwd_d;
      rrdy_q   <= rrdy_d;
      wrdy_q   <= wrdy_d;
      rdata_q  <= rdata_d;
`ifdef LSU_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign mem_read_valid    = mrv_q;
  assign mem_read_address  = mra_q;
  assign mem_write_valid   = mwv_q;
  assign mem_write_address = mwa_q;
  assign mem_write_data    = mwd_q;
  assign lsu_read_ready    = rrdy_q;
  assign lsu_write_ready   = wrdy_q;
  assign busy              = (state_q != IDLE);
  assign grant_id          = grant_q;
`ifdef LSU_ARB_TIMEOUT_EN
  assign timeout_error     = timeout_q;
`else
  assign timeout_error     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_arbiter
//   Directed, table-driven bench for lsu_mem_arbiter (4 LSUs, 8-bit address
//   and data). Each table row is one full transaction starting from IDLE with
//   a hand-computed expected grant, memory request and LSU response. Extra
//   hand-written sequences cover early valid drop, ignored memory ready,
//   idle ready pulses, reset mid-write and (with LSU_ARB_TIMEOUT_EN) timeout.
// ---------------------------------------------------------------------------
module tb_lsu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  lsu_read_valid;
  logic [31:0] lsu_read_address;
  logic [3:0]  lsu_read_ready;
  logic [31:0] lsu_read_data;
  logic [3:0]  lsu_write_valid;
  logic [31:0] lsu_write_address;
  logic [31:0] lsu_write_data;
  logic [3:0]  lsu_write_ready;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [7:0]  mem_read_data;
  logic        mem_write_valid;
  logic [7:0]  mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_ready;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_error;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .NUM_LSUS       (4),
    .ADDR_BITS      (8),
    .DATA_BITS      (8),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .lsu_read_valid    (lsu_read_valid),
    .lsu_read_address  (lsu_read_address),
    .lsu_read_ready    (lsu_read_ready),
    .lsu_read_data     (lsu_read_data),
    .lsu_write_valid   (lsu_write_valid),
    .lsu_write_address (lsu_write_address),
    .lsu_write_data    (lsu_write_data),
    .lsu_write_ready   (lsu_write_ready),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready),
    .busy              (busy),
    .grant_id          (grant_id),
    .timeout_error     (timeout_error)
  );

  // Fixed per-channel addresses/data: LSU0..3 from low slice to high slice
  assign lsu_read_address  = 32'h73_10_51_40;
  assign lsu_write_address = 32'hA3_92_20_80;
  assign lsu_write_data    = 32'h6B_5A_3C_11;

  logic [7:0] rd_a [4];
  assign rd_a[0] = lsu_read_data[7:0];
  assign rd_a[1] = lsu_read_data[15:8];
  assign rd_a[2] = lsu_read_data[23:16];
  assign rd_a[3] = lsu_read_data[31:24];

  typedef struct {
    logic [3:0] rv;
    logic [3:0] wv;
    logic [1:0] g;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         lat;
    int         hold;
  } row_t;

  row_t       tbl [12];
  logic [7:0] exp_rd [4];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdata_all();
    for (int i = 0; i < 4; i++) chk("lsu_read_data_hold", 32'(rd_a[i]), 32'(exp_rd[i]));
  endtask

  task automatic run_row(input row_t r);
    logic [3:0] oh;
    oh = 4'b0001 << r.g;
    lsu_read_valid  = r.rv;
    lsu_write_valid = r.wv;
    tick();
    chk("grant_id", 32'(grant_id), 32'(r.g));
    chk("busy_grant", 32'(busy), 32'd1);
    chk("mem_read_valid", 32'(mem_read_valid), 32'(r.rd));
    chk("mem_write_valid", 32'(mem_write_valid), 32'(!r.rd));
    if (r.rd) chk("mem_read_address", 32'(mem_read_address), 32'(r.addr));
    else begin
      chk("mem_write_address", 32'(mem_write_address), 32'(r.addr));
      chk("mem_write_data", 32'(mem_write_data), 32'(r.wdata));
    end
    for (int c = 0; c < r.lat; c++) begin
      tick();
      if (r.rd) begin
        chk("rd_hold_valid", 32'(mem_read_valid), 32'd1);
        chk("rd_hold_addr", 32'(mem_read_address), 32'(r.addr));
      end else begin
        chk("wr_hold_valid", 32'(mem_write_valid), 32'd1);
        chk("wr_hold_data", 32'(mem_write_data), 32'(r.wdata));
      end
    end
    if (r.rd) begin
      mem_read_ready = 1'b1;
      mem_read_data  = r.rdata;
    end else begin
      mem_write_ready = 1'b1;
    end
    tick();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'hEE;
    if (r.rd) begin
      exp_rd[r.g] = r.rdata;
      chk("lsu_read_ready", 32'(lsu_read_ready), 32'(oh));
      chk("lsu_read_data", 32'(rd_a[r.g]), 32'(r.rdata));
      chk("mem_read_valid_drop", 32'(mem_read_valid), 32'd0);
    end else begin
      chk("lsu_write_ready", 32'(lsu_write_ready), 32'(oh));
      chk("mem_write_valid_drop", 32'(mem_write_valid), 32'd0);
    end
    for (int c = 0; c < r.hold; c++) begin
      tick();
      chk("ready_held", 32'(r.rd ? lsu_read_ready : lsu_write_ready), 32'(oh));
    end
    if (r.rd) lsu_read_valid[r.g] = 1'b0;
    else      lsu_write_valid[r.g] = 1'b0;
    tick();
    chk("ready_clear_rd", 32'(lsu_read_ready), 32'd0);
    chk("ready_clear_wr", 32'(lsu_write_ready), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // rv, wv, grant, is_read, addr, wdata, rdata, mem latency, ready hold
    tbl[0]  = '{4'b1111, 4'b0000, 2'd0, 1'b1, 8'h40, 8'h00, 8'h01, 1, 0};
    tbl[1]  = '{4'b1110, 4'b0000, 2'd1, 1'b1, 8'h51, 8'h00, 8'h02, 0, 0};
    tbl[2]  = '{4'b1100, 4'b0000, 2'd2, 1'b1, 8'h10, 8'h00, 8'hA5, 3, 2};
    tbl[3]  = '{4'b1000, 4'b0000, 2'd3, 1'b1, 8'h73, 8'h00, 8'h7E, 2, 0};
    tbl[4]  = '{4'b0001, 4'b0000, 2'd0, 1'b1, 8'h40, 8'h00, 8'hC3, 1, 0};
    tbl[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 8'h51, 8'h00, 8'h99, 1, 0};
    tbl[6]  = '{4'b0000, 4'b0010, 2'd1, 1'b0, 8'h20, 8'h3C, 8'h00, 2, 1};
    tbl[7]  = '{4'b0000, 4'b1001, 2'd3, 1'b0, 8'hA3, 8'h6B, 8'h00, 0, 0};
    tbl[8]  = '{4'b0000, 4'b0001, 2'd0, 1'b0, 8'h80, 8'h11, 8'h00, 1, 0};
    tbl[9]  = '{4'b0101, 4'b0100, 2'd2, 1'b1, 8'h10, 8'h00, 8'h5C, 1, 0};
    tbl[10] = '{4'b0001, 4'b0100, 2'd0, 1'b1, 8'h40, 8'h00, 8'hFF, 0, 0};
    tbl[11] = '{4'b0000, 4'b0100, 2'd2, 1'b0, 8'h92, 8'h5A, 8'h00, 1, 0};

    for (int i = 0; i < 4; i++) exp_rd[i] = 8'h00;
    reset           = 1'b0;
    lsu_read_valid  = '0;
    lsu_write_valid = '0;
    mem_read_ready  = 1'b0;
    mem_read_data   = 8'h00;
    mem_write_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_mem_read_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_mem_write_valid", 32'(mem_write_valid), 32'd0);
    chk("rst_mem_read_address", 32'(mem_read_address), 32'd0);
    chk("rst_mem_write_data", 32'(mem_write_data), 32'd0);
    chk("rst_lsu_ready", 32'({lsu_read_ready, lsu_write_ready}), 32'd0);
    chk("rst_lsu_read_data", lsu_read_data, 32'd0);
    chk("rst_timeout_error", 32'(timeout_error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_row(tbl[i]);

    // Memory ready pulses while idle with nothing requested: no effect
    mem_read_ready  = 1'b1;
    mem_read_data   = 8'h77;
    mem_write_ready = 1'b1;
    tick();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_mem_valid", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    chk("idle_lsu_ready", 32'({lsu_read_ready, lsu_write_ready}), 32'd0);
    chk_rdata_all();
    // rr_ptr still 3 after last row: all-request burst grants LSU3 first
    run_row('{4'b1111, 4'b0000, 2'd3, 1'b1, 8'h73, 8'h00, 8'h42, 1, 0});
    lsu_read_valid = '0;
    tick();
    chk("no_grant_after_clear", 32'(busy), 32'd0);

    // LSU0 drops valid right after grant; stray write ready is ignored
    lsu_read_valid = 4'b0001;
    tick();
    chk("early_grant", 32'(grant_id), 32'd0);
    lsu_read_valid  = '0;
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    chk("early_still_valid", 32'(mem_read_valid), 32'd1);
    chk("stray_wr_ready", 32'(lsu_write_ready), 32'd0);
    chk("stray_wr_valid", 32'(mem_write_valid), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 8'h6D;
    tick();
    mem_read_ready = 1'b0;
    exp_rd[0] = 8'h6D;
    chk("early_ready_pulse", 32'(lsu_read_ready), 32'b0001);
    chk("early_data", 32'(rd_a[0]), 32'h6D);
    tick();
    chk("early_ready_one_cycle", 32'(lsu_read_ready), 32'd0);
    chk("early_idle", 32'(busy), 32'd0);

    // Reset in the middle of a write (rr_ptr is 1 here)
    lsu_write_valid = 4'b0010;
    tick();
    chk("mw_grant", 32'(grant_id), 32'd1);
    chk("mw_valid", 32'(mem_write_valid), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mw_rst_valid", 32'(mem_write_valid), 32'd0);
    chk("mw_rst_busy", 32'(busy), 32'd0);
    chk("mw_rst_grant", 32'(grant_id), 32'd0);
    chk("mw_rst_addr", 32'(mem_write_address), 32'd0);
    for (int i = 0; i < 4; i++) exp_rd[i] = 8'h00;
    chk_rdata_all();
    lsu_write_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    // rr_ptr must be 0: with LSU0 and LSU3 requesting, LSU0 wins
    run_row('{4'b1001, 4'b0000, 2'd0, 1'b1, 8'h40, 8'h00, 8'h5E, 0, 0});
    lsu_read_valid = '0;
    tick();

`ifdef LSU_ARB_TIMEOUT_EN
    run_row('{4'b0100, 4'b0000, 2'd2, 1'b1, 8'h10, 8'h00, 8'hB7, 1, 0});
    lsu_read_valid = 4'b0100;
    tick();
    chk("to_grant", 32'(grant_id), 32'd2);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("to_waiting", 32'({busy, lsu_read_ready}), 32'({1'b1, 4'b0000}));
    end
    tick();
    chk("to_ready", 32'(lsu_read_ready), 32'b0100);
    chk("to_data_zero", 32'(rd_a[2]), 32'd0);
    chk("to_mem_valid_drop", 32'(mem_read_valid), 32'd0);
    chk("to_flag", 32'(timeout_error), 32'd1);
    lsu_read_valid = '0;
    tick();
    chk("to_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("to_flag_sticky", 32'(timeout_error), 32'd1);
    reset = 1'b0;
    #1;
    chk("to_flag_reset", 32'(timeout_error), 32'd0);
    reset = 1'b1;
    tick();
`else
    chk("timeout_error_tied", 32'(timeout_error), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/lsu_mem_arbiter.md
LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

Interface
REQ-001 Parameter: NUM_LSUS, 4, number of LSU requester channels (2..16).
REQ-002 Parameter: ADDR_BITS, 8, memory address width.
REQ-003 Parameter: DATA_BITS, 8, memory data width.
REQ-004 Parameter: TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when LSU_ARB_TIMEOUT_EN is defined.
REQ-005 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port: reset  in  1  reset, asynchronous, active-low (0 = in reset).
REQ-007 Port: lsu_read_valid  in  NUM_LSUS  per-LSU load request.
REQ-008 Port: lsu_read_address  in  NUM_LSUS*ADDR_BITS  per-LSU load address, channel i at slice i.
REQ-009 Port: lsu_read_ready  out  NUM_LSUS  per-LSU load completion.
REQ-010 Port: lsu_read_data  out  NUM_LSUS*DATA_BITS  per-LSU returned load data.
REQ-011 Port: lsu_write_valid  in  NUM_LSUS  per-LSU store request.
REQ-012 Port: lsu_write_address  in  NUM_LSUS*ADDR_BITS  per-LSU store address.
REQ-013 Port: lsu_write_data  in  NUM_LSUS*DATA_BITS  per-LSU store data.
REQ-014 Port: lsu_write_ready  out  NUM_LSUS  per-LSU store completion.
REQ-015 Port: mem_read_valid / mem_read_address  out  1 / ADDR_BITS  load request to data memory.
REQ-016 Port: mem_read_ready / mem_read_data  in  1 / DATA_BITS  load response from data memory.
REQ-017 Port: mem_write_valid / mem_write_address / mem_write_data  out  1 / ADDR_BITS / DATA_BITS  store request.
REQ-018 Port: mem_write_ready  in  1  store acknowledge.
REQ-019 Port: busy  out  1  high whenever state is not IDLE.
REQ-020 Port: grant_id  out  $clog2(NUM_LSUS)  currently or last granted LSU index.
REQ-021 Port: timeout_error  out  1  sticky watchdog flag.

Function
REQ-022 States SHALL be IDLE, MEM_READ, MEM_WRITE, RELEASE; exactly one memory transaction is outstanding at a time.
REQ-023 IDLE: requesters SHALL be scanned round-robin starting at rr_ptr; the first index with read_valid or write_valid is granted; if both are high on that index, read wins.
REQ-024 On grant at edge t, mem_*_valid, address (and write data) SHALL be registered from the granted slice and visible after edge t (one-cycle latency); grant_id updates at the same edge.
REQ-025 MEM_READ/MEM_WRITE: valid, address and data SHALL be held stable until mem_*_ready is sampled high.
REQ-026 On mem_read_ready: latch mem_read_data into lsu_read_data[g], drop mem_read_valid, set lsu_read_ready[g], go to RELEASE; on mem_write_ready: drop mem_write_valid, set lsu_write_ready[g], go to RELEASE.
REQ-027 RELEASE: lsu_*_ready[g] SHALL stay high until the granted LSU's matching valid is sampled low; then ready clears, rr_ptr = (g+1) mod NUM_LSUS (wrap N-1 -> 0), state -> IDLE.
REQ-028 Minimum LSU-to-LSU turnaround SHALL be: grant, memory cycle(s), RELEASE, IDLE; no grant in the cycle RELEASE exits.
REQ-029 A granted LSU dropping valid before memory responds SHALL NOT abort the transaction; ready pulses for exactly one cycle in RELEASE.
REQ-030 mem_*_ready asserted while not in the matching MEM_* state SHALL be ignored.
REQ-031 lsu_read_data per channel SHALL hold its last value until the next read granted to that channel.
REQ-032 No requests: remain in IDLE, all valid/ready outputs low, rr_ptr unchanged.

Reset
REQ-033 Reset low SHALL immediately force IDLE, rr_ptr=0, grant_id=0, all valid/ready outputs 0, all address/data outputs 0, timeout_error 0, including mid-transaction.
REQ-034 After reset release, first arbitration SHALL occur at the first rising edge with reset high.

Configuration
REQ-035 Macro LSU_ARB_TIMEOUT_EN defined: a counter SHALL run in MEM_READ/MEM_WRITE; at TIMEOUT_CYCLES without ready, drop mem valid, return lsu_read_data[g]=0 where applicable, set lsu_*_ready[g], go to RELEASE, set timeout_error (cleared only by reset).
REQ-036 Macro undefined: no counter; MEM_* waits indefinitely; timeout_error tied 0; port list unchanged.

Verification
REQ-037 LSU2 read addr 0x10, memory returns 0xA5 after 3 cycles -> mem_read_address=0x10, lsu_read_data[2]=0xA5, lsu_read_ready[2] high until LSU2 drops valid.
REQ-038 All 4 LSUs request reads simultaneously from reset -> grants in order 0,1,2,3, then 0 again for a re-request (wrap).
REQ-039 LSU1 read and write both valid -> read served first, write served on a later grant with data 0x3C at addr 0x20.
REQ-040 Reset low during MEM_WRITE -> mem_write_valid=0 and busy=0 immediately, rr_ptr=0 after release.
REQ-041 LSU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never ready -> after 8 cycles lsu_read_ready high, data 0x00, timeout_error=1 until reset.
REQ-042 mem_read_ready pulsed while IDLE with no requests -> no output changes.
